// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares the single register-file write port among NREQ requesters,
// with locked bursts and XZR write suppression. Define WBARB_FIXED_PRI_EN for fixed priority.
module regfile_wb_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_lock,
    input  logic [NREQ*ADDR_W-1:0]    req_addr,
    input  logic [NREQ*DATA_W-1:0]    req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      port_stall,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [$clog2(NREQ)-1:0]   grant_id
);

    localparam int GID_W = $clog2(NREQ);

    // Handshake: a beat from requester i is accepted in the cycle where
    // req_valid[i] & req_ready[i]; ready never depends on req_data/req_addr.
    typedef enum logic {ARB, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [GID_W-1:0]  owner_q, owner_d;
    logic [GID_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic              arb_found;
    logic [GID_W-1:0]  arb_idx;
    logic [GID_W:0]    cand;
    logic [NREQ-1:0]   ready;
    logic              accept;
    logic [GID_W-1:0]  accept_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Scan from rr_ptr with wrap; cand carries one extra bit so the sum never overflows.
    // In fixed-priority builds rr_ptr never leaves 0, so the scan starts at index 0.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (GID_W+1)'(k);
            if (cand >= (GID_W+1)'(NREQ)) begin
                cand = cand - (GID_W+1)'(NREQ);
            end
            if (!arb_found && req_valid[cand[GID_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[GID_W-1:0];
            end
        end
    end

    always_comb begin
        ready = '0;
        if (!reset && !port_stall) begin
            if (state_q == ARB) begin
                if (arb_found) begin
                    ready[arb_idx] = 1'b1;
                end
            end else begin
                ready[owner_q] = req_valid[owner_q];
            end
        end
    end

    assign req_ready  = ready;
    assign accept     = |ready;
    assign accept_idx = (state_q == ARB) ? arb_idx : owner_q;
    assign sel_addr   = req_addr[accept_idx*ADDR_W +: ADDR_W];
    assign sel_data   = req_data[accept_idx*DATA_W +: DATA_W];

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (!port_stall) begin
            case (state_q)
                ARB: begin
                    if (accept) begin
`ifdef WBARB_FIXED_PRI_EN
                        rr_ptr_d = '0;
`else
                        rr_ptr_d = (arb_idx == GID_W'(NREQ-1)) ? '0 : arb_idx + 1'b1;
`endif
                        if (req_lock[arb_idx]) begin
                            state_d = LOCKED;
                            owner_d = arb_idx;
                        end
                    end
                end
                LOCKED: begin
                    // Either an unlocked final beat or the owner going idle ends the burst.
                    if (!(req_valid[owner_q] && req_lock[owner_q])) begin
                        state_d = ARB;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            grant_id <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            // XZR writes are accepted but never reach the decoder enable.
            wr_en    <= accept && (sel_addr != {ADDR_W{1'b1}});
            if (accept) begin
                wr_addr  <= sel_addr;
                wr_data  <= sel_data;
                grant_id <= accept_idx;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the arbitration rules.
module tb_regfile_wb_arbiter;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;
    localparam int GID_W  = 2;
    localparam int EXP_W  = 1 + ADDR_W + DATA_W + GID_W;

    logic                     clk;
    logic                     reset;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_lock;
    logic [NREQ*ADDR_W-1:0]   req_addr;
    logic [NREQ*DATA_W-1:0]   req_data;
    logic [NREQ-1:0]          req_ready;
    logic                     port_stall;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [GID_W-1:0]         grant_id;

    int vectors    = 0;
    int miscompares = 0;

    regfile_wb_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_lock(req_lock),
        .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .port_stall(port_stall), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .grant_id(grant_id)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: lock flag, owner, round-robin pointer, expected write port.
    bit                m_locked;
    int                m_owner;
    int                m_ptr;
    logic              m_wr_en;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic [GID_W-1:0]  m_gid;
    logic [EXP_W-1:0]  exp_q[$];

    function automatic int model_pick();
        if (reset || port_stall) return -1;
        if (m_locked) return req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] model_ready();
        logic [NREQ-1:0] r;
        int w;
        r = '0;
        w = model_pick();
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic model_advance();
        int w;
        w = model_pick();
        if (reset) begin
            m_locked = 0; m_owner = 0; m_ptr = 0;
            m_wr_en = 1'b0; m_addr = '0; m_data = '0; m_gid = '0;
        end else if (w < 0) begin
            m_wr_en = 1'b0;
            if (!port_stall && m_locked && !req_valid[m_owner]) m_locked = 0;
        end else begin
            m_addr  = req_addr[w*ADDR_W +: ADDR_W];
            m_data  = req_data[w*DATA_W +: DATA_W];
            m_gid   = GID_W'(w);
            m_wr_en = (m_addr != {ADDR_W{1'b1}});
            if (!m_locked) begin
`ifndef WBARB_FIXED_PRI_EN
                m_ptr = (w + 1) % NREQ;
`endif
                m_owner = w;
            end
            m_locked = req_lock[w];
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver: apply one cycle of inputs, compare ready and the registered write port.
    task automatic step(input logic rst, input logic stall,
                        input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                        input logic [NREQ*ADDR_W-1:0] a, input logic [NREQ*DATA_W-1:0] d,
                        output logic [NREQ-1:0] rdy);
        logic [EXP_W-1:0] e;
        @(negedge clk);
        reset = rst; port_stall = stall; req_valid = v; req_lock = l;
        req_addr = a; req_data = d;
        #1;
        check("req_ready", req_ready, model_ready());
        rdy = req_ready;
        model_advance();
        exp_q.push_back({m_wr_en, m_addr, m_data, m_gid});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("wr_en",    wr_en,    e[EXP_W-1]);
        check("wr_addr",  wr_addr,  e[EXP_W-2 -: ADDR_W]);
        check("wr_data",  wr_data,  e[DATA_W+GID_W-1 -: DATA_W]);
        check("grant_id", grant_id, e[GID_W-1:0]);
    endtask

    function automatic logic [NREQ*ADDR_W-1:0] pa(input int a0, input int a1, input int a2);
        return {ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
    endfunction

    function automatic logic [NREQ*DATA_W-1:0] pd(input logic [63:0] d0, input logic [63:0] d1,
                                                   input logic [63:0] d2);
        return {d2, d1, d0};
    endfunction

    initial begin
        logic [NREQ-1:0] rdy;
        int g;
        reset = 1'b1; port_stall = 1'b0; req_valid = '0; req_lock = '0;
        req_addr = '0; req_data = '0;
        m_locked = 0; m_owner = 0; m_ptr = 0;
        m_wr_en = 1'b0; m_addr = '0; m_data = '0; m_gid = '0;

        // Reset state
        step(1, 0, 3'b111, 3'b000, pa(1, 2, 3), pd(1, 2, 3), rdy);
        check("rst_ready", rdy, 3'b000);
        step(1, 0, 3'b000, 3'b000, pa(0, 0, 0), pd(0, 0, 0), rdy);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_grant", grant_id, 0);

        // Single requester write, one-cycle latency
        step(0, 0, 3'b001, 3'b000, pa(5, 0, 0), pd(64'hAA, 0, 0), rdy);
        check("t1_ready", rdy, 3'b001);
        check("t1_wr_en", wr_en, 1);
        check("t1_wr_addr", wr_addr, 5);
        check("t1_wr_data", wr_data, 64'hAA);
        check("t1_grant", grant_id, 0);
        step(0, 0, 3'b000, 3'b000, pa(7, 7, 7), pd(1, 1, 1), rdy);
        check("t1_pulse_end", wr_en, 0);
        check("t1_addr_hold", wr_addr, 5);

        // All requesters valid for six cycles
        step(1, 0, 3'b000, 3'b000, pa(0, 0, 0), pd(0, 0, 0), rdy);
        for (int k = 0; k < 6; k++) begin
`ifdef WBARB_FIXED_PRI_EN
            g = 0;
`else
            g = k % 3;
`endif
            step(0, 0, 3'b111, 3'b000, pa(10, 11, 12), pd(100 + k, 200 + k, 300 + k), rdy);
            check("t2_ready", rdy, 3'b001 << g);
            check("t2_grant", grant_id, g);
            check("t2_wr_en", wr_en, 1);
        end

        // XZR destination: ready as usual, no write enable
        step(1, 0, 3'b000, 3'b000, pa(0, 0, 0), pd(0, 0, 0), rdy);
        step(0, 0, 3'b010, 3'b000, pa(0, 31, 0), pd(0, 64'h55, 0), rdy);
        check("t3_ready", rdy, 3'b010);
        check("t3_wr_en", wr_en, 0);
        check("t3_grant", grant_id, 1);
        check("t3_wr_addr", wr_addr, 31);

        // Locked burst by requester 2, then arbitration resumes at 0
        step(1, 0, 3'b000, 3'b000, pa(0, 0, 0), pd(0, 0, 0), rdy);
        step(0, 0, 3'b100, 3'b100, pa(1, 2, 3), pd(1, 2, 30), rdy);
        check("t4_ready0", rdy, 3'b100);
        step(0, 0, 3'b111, 3'b100, pa(1, 2, 4), pd(1, 2, 31), rdy);
        check("t4_ready1", rdy, 3'b100);
        step(0, 0, 3'b111, 3'b100, pa(1, 2, 5), pd(1, 2, 32), rdy);
        check("t4_ready2", rdy, 3'b100);
        step(0, 0, 3'b111, 3'b000, pa(1, 2, 6), pd(1, 2, 33), rdy);
        check("t4_ready3", rdy, 3'b100);
        check("t4_grant3", grant_id, 2);
        check("t4_wr_addr3", wr_addr, 6);
        step(0, 0, 3'b111, 3'b000, pa(1, 2, 7), pd(1, 2, 34), rdy);
        check("t4_after", rdy, 3'b001);
        check("t4_grant_after", grant_id, 0);

        // Stall holds the pointer
        step(1, 0, 3'b000, 3'b000, pa(0, 0, 0), pd(0, 0, 0), rdy);
        step(0, 0, 3'b011, 3'b000, pa(8, 9, 0), pd(8, 9, 0), rdy);
        check("t5_pre", rdy, 3'b001);
        for (int k = 0; k < 2; k++) begin
            step(0, 1, 3'b011, 3'b000, pa(8, 9, 0), pd(8, 9, 0), rdy);
            check("t5_stall_ready", rdy, 3'b000);
            check("t5_stall_wr_en", wr_en, 0);
        end
        step(0, 0, 3'b011, 3'b000, pa(8, 9, 0), pd(8, 9, 0), rdy);
`ifdef WBARB_FIXED_PRI_EN
        check("t5_post", rdy, 3'b001);
`else
        check("t5_post", rdy, 3'b010);
`endif

        // Owner drops valid mid-burst: idle cycle, then arbitration
        step(1, 0, 3'b000, 3'b000, pa(0, 0, 0), pd(0, 0, 0), rdy);
        step(0, 0, 3'b001, 3'b001, pa(3, 4, 5), pd(3, 4, 5), rdy);
        check("tdrop_lock", rdy, 3'b001);
        step(0, 0, 3'b110, 3'b000, pa(3, 4, 5), pd(3, 4, 5), rdy);
        check("tdrop_idle", rdy, 3'b000);
        check("tdrop_wr_en", wr_en, 0);
        step(0, 0, 3'b110, 3'b000, pa(3, 4, 5), pd(3, 4, 5), rdy);
        check("tdrop_resume", rdy, 3'b010);

        // Reset while locked to owner 1
        step(1, 0, 3'b000, 3'b000, pa(0, 0, 0), pd(0, 0, 0), rdy);
        step(0, 0, 3'b010, 3'b010, pa(0, 6, 0), pd(0, 66, 0), rdy);
        check("t6_lock", rdy, 3'b010);
        step(0, 0, 3'b111, 3'b010, pa(1, 7, 2), pd(1, 67, 2), rdy);
        check("t6_locked_ready", rdy, 3'b010);
        step(1, 0, 3'b111, 3'b010, pa(1, 8, 2), pd(1, 68, 2), rdy);
        check("t6_rst_ready", rdy, 3'b000);
        check("t6_rst_wr_en", wr_en, 0);
        check("t6_rst_grant", grant_id, 0);
        step(0, 0, 3'b010, 3'b000, pa(0, 9, 0), pd(0, 69, 0), rdy);
        check("t6_release", rdy, 3'b010);
        check("t6_grant", grant_id, 1);
        check("t6_wr_en", wr_en, 1);

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            logic [NREQ*ADDR_W-1:0] a;
            logic [NREQ*DATA_W-1:0] d;
            for (int i = 0; i < NREQ; i++) begin
                a[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 31));
                d[i*DATA_W +: DATA_W] = {$urandom, $urandom};
            end
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                 NREQ'($urandom_range(0, 7)), NREQ'($urandom_range(0, 7)), a, d, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
